dmem_bridge: RTL and testbench



---
 rtl/dmem_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: data-memory port to synchronous single-port word SRAM bridge.
// Turns a hold-until-ready core request into one SRAM cycle with byte enables
// and lane-replicated write data, adds WAIT_STATES latency cycles and answers
// with a one-cycle dmem_ready pulse. Misaligned/illegal accesses are answered
// with dmem_err and never reach the SRAM.
// Optional feature: define DMEM_MMIO_EN to add a console byte register at
// MMIO_ADDR (writes pulse console_valid, reads return 0, no SRAM access).
module dmem_bridge #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           dmem_addr,
    input  logic                  dmem_r_enable,
    input  logic                  dmem_w_enable,
    input  logic [1:0]            dmem_w_size,
    input  logic [31:0]           dmem_w_data,
    output logic [31:0]           dmem_r_data,
    output logic                  dmem_ready,
    output logic                  dmem_err,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
`ifdef DMEM_MMIO_EN
   ,output logic [7:0]            console_data,
    output logic                  console_valid
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  isRead_q, isRead_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  en_q, en_d;
    logic [3:0]            we_q, we_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
`ifdef DMEM_MMIO_EN
    logic [7:0]            consData_q, consData_d;
    logic                  consValid_q, consValid_d;
`endif

    logic        reqWrite;
    logic        reqRead;
    logic        illegal;
    logic [3:0]  laneWe;
    logic [31:0] laneWdata;
    logic        unusedBits;

    assign reqWrite = dmem_w_enable;
    assign reqRead  = dmem_r_enable & ~dmem_w_enable;

    // Only the word-address field reaches the SRAM; higher bits wrap away.
    assign unusedBits = ^{dmem_addr[31:DEPTH_LOG2+2], MMIO_ADDR};

    // Decode legality, byte enables and replicated write data for the request.
    always_comb begin
        illegal   = 1'b0;
        laneWe    = 4'b0000;
        laneWdata = 32'h0;
        if (reqWrite) begin
            case (dmem_w_size)
                2'b00: begin
                    laneWe    = 4'b0001 << dmem_addr[1:0];
                    laneWdata = {4{dmem_w_data[7:0]}};
                end
                2'b01: begin
                    illegal   = dmem_addr[0];
                    laneWe    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                    laneWdata = {2{dmem_w_data[15:0]}};
                end
                2'b10: begin
                    illegal   = (dmem_addr[1:0] != 2'b00);
                    laneWe    = 4'b1111;
                    laneWdata = dmem_w_data;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            illegal = (dmem_addr[1:0] != 2'b00);
        end
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        isRead_d = isRead_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        en_d     = 1'b0;
        we_d     = 4'b0000;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef DMEM_MMIO_EN
        consData_d  = consData_q;
        consValid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (reqWrite || reqRead) begin
                    isRead_d = reqRead;
                    if (illegal) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end
`ifdef DMEM_MMIO_EN
                    else if (dmem_addr == MMIO_ADDR) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        if (reqWrite) begin
                            consValid_d = 1'b1;
                            consData_d  = dmem_w_data[7:0];
                        end else begin
                            rdata_d = 32'h0;
                        end
                    end
`endif
                    else begin
                        state_d = ACCESS;
                        en_d    = 1'b1;
                        we_d    = laneWe;
                        addr_d  = dmem_addr[DEPTH_LOG2+1:2];
                        wdata_d = laneWdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (isRead_q) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            isRead_q <= 1'b0;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
`ifdef DMEM_MMIO_EN
            consData_q  <= 8'h0;
            consValid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            isRead_q <= isRead_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef DMEM_MMIO_EN
            consData_q  <= consData_d;
            consValid_q <= consValid_d;
`endif
        end
    end

    assign dmem_r_data = rdata_q;
    assign dmem_ready  = ready_q;
    assign dmem_err    = err_q;
    assign sram_en     = en_q;
    assign sram_we     = we_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
`ifdef DMEM_MMIO_EN
    assign console_data  = consData_q;
    assign console_valid = consValid_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed self-checking bench for dmem_bridge.
// dutA uses default timing with a behavioural byte-writable SRAM; dutB uses
// three wait states with a read-only SRAM model that only presents valid data
// once the advertised latency has elapsed.
module tb_dmem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT A signals
    logic        resetA;
    logic [31:0] addrInA, wDataInA, rDataA, sramRdataA, wdataA;
    logic        rEnA, wEnA, readyA, errA, enA;
    logic [1:0]  sizeA;
    logic [3:0]  weA;
    logic [9:0]  addrA;
    // DUT B signals
    logic        resetB;
    logic [31:0] addrInB, wDataInB, rDataB, sramRdataB, wdataB;
    logic        rEnB, wEnB, readyB, errB, enB;
    logic [1:0]  sizeB;
    logic [3:0]  weB;
    logic [9:0]  addrB;
`ifdef DMEM_MMIO_EN
    logic [7:0]  consDataA, consDataB;
    logic        consValidA, consValidB;
`endif

    dmem_bridge #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dutA (
        .clk(clk), .reset(resetA), .dmem_addr(addrInA), .dmem_r_enable(rEnA),
        .dmem_w_enable(wEnA), .dmem_w_size(sizeA), .dmem_w_data(wDataInA),
        .dmem_r_data(rDataA), .dmem_ready(readyA), .dmem_err(errA),
        .sram_en(enA), .sram_we(weA), .sram_addr(addrA), .sram_wdata(wdataA),
        .sram_rdata(sramRdataA)
`ifdef DMEM_MMIO_EN
       ,.console_data(consDataA), .console_valid(consValidA)
`endif
    );

    dmem_bridge #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dutB (
        .clk(clk), .reset(resetB), .dmem_addr(addrInB), .dmem_r_enable(rEnB),
        .dmem_w_enable(wEnB), .dmem_w_size(sizeB), .dmem_w_data(wDataInB),
        .dmem_r_data(rDataB), .dmem_ready(readyB), .dmem_err(errB),
        .sram_en(enB), .sram_we(weB), .sram_addr(addrB), .sram_wdata(wdataB),
        .sram_rdata(sramRdataB)
`ifdef DMEM_MMIO_EN
       ,.console_data(consDataB), .console_valid(consValidB)
`endif
    );

    // SRAM model for dutA: byte-writable, one-cycle synchronous read.
    logic [31:0] memA [0:1023];
    always @(posedge clk) begin
        if (enA) begin
            if (weA == 4'b0000) begin
                sramRdataA <= memA[addrA];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (weA[i]) memA[addrA][i*8 +: 8] <= wdataA[i*8 +: 8];
                end
            end
        end
    end

    // SRAM model for dutB: garbage until WAIT_STATES+1 cycles after sram_en.
    logic [3:0] pendB = 4'd0;
    logic [9:0] pendAddrB = 10'd0;
    always @(posedge clk) begin
        if (enB && weB == 4'b0000) begin
            sramRdataB <= 32'hBAD0_BAD0;
            pendB      <= 4'd3;
            pendAddrB  <= addrB;
        end else if (pendB != 4'd0) begin
            pendB <= pendB - 4'd1;
            if (pendB == 4'd1) sramRdataB <= 32'hC0DE_0000 | {22'd0, pendAddrB};
        end
    end

    // Views of the DUT selected by the running access.
    logic        selB = 1'b0;
    logic        curEn, curReady, curErr;
    logic [3:0]  curWe;
    logic [9:0]  curAddr;
    logic [31:0] curWdata, curRdata;
    assign curEn    = selB ? enB    : enA;
    assign curReady = selB ? readyB : readyA;
    assign curErr   = selB ? errB   : errA;
    assign curWe    = selB ? weB    : weA;
    assign curAddr  = selB ? addrB  : addrA;
    assign curWdata = selB ? wdataB : wdataA;
    assign curRdata = selB ? rDataB : rDataA;

    int          gotReady, gotEnCycle, gotEnCount, gotAfter, gotConsCount;
    logic        gotErr;
    logic [31:0] gotRdata, gotWdata;
    logic [3:0]  gotWe;
    logic [9:0]  gotAddr;
    logic [7:0]  gotConsData;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit onB, input logic [31:0] addr, input bit w,
                                 input bit r, input logic [1:0] size, input logic [31:0] data);
        if (onB) begin
            addrInB = addr; wEnB = w; rEnB = r; sizeB = size; wDataInB = data;
        end else begin
            addrInA = addr; wEnA = w; rEnA = r; sizeA = size; wDataInA = data;
        end
    endtask

    // Holds a request until dmem_ready (bounded), recording what the SRAM side saw.
    task automatic runAccess(input bit onB, input logic [31:0] addr, input bit w,
                             input bit r, input logic [1:0] size, input logic [31:0] data);
        selB = onB;
        gotReady = -1; gotEnCycle = -1; gotEnCount = 0; gotConsCount = 0;
        gotErr = 1'b0; gotRdata = 32'h0; gotWe = 4'h0; gotAddr = 10'h0;
        gotWdata = 32'h0; gotConsData = 8'h0;
        applyStimulus(onB, addr, w, r, size, data);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (curEn) begin
                gotEnCount++; gotEnCycle = k;
                gotWe = curWe; gotAddr = curAddr; gotWdata = curWdata;
            end
`ifdef DMEM_MMIO_EN
            if (!onB && consValidA) begin
                gotConsCount++; gotConsData = consDataA;
            end
`endif
            if (curReady) begin
                gotReady = k; gotErr = curErr; gotRdata = curRdata;
                break;
            end
        end
        applyStimulus(onB, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        gotAfter = int'(curReady);
    endtask

    initial begin
        resetA = 1'b1; resetB = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rst ready", 32'(readyA), 32'h0);
        checkOutput("rst err", 32'(errA), 32'h0);
        checkOutput("rst en", 32'(enA), 32'h0);
        checkOutput("rst we", 32'(weA), 32'h0);
        checkOutput("rst addr", 32'(addrA), 32'h0);
        checkOutput("rst wdata", wdataA, 32'h0);
        checkOutput("rst rdata", rDataA, 32'h0);
`ifdef DMEM_MMIO_EN
        checkOutput("rst console", {23'd0, consValidA, consDataA}, 32'h0);
`endif
        resetA = 1'b0; resetB = 1'b0;
        @(negedge clk);

        runAccess(1'b0, 32'h100, 1'b1, 1'b0, 2'b10, 32'hDEAD_BEEF);
        checkOutput("wr en cycle", gotEnCycle, 1);
        checkOutput("wr en count", gotEnCount, 1);
        checkOutput("wr we", 32'(gotWe), 32'hF);
        checkOutput("wr addr", 32'(gotAddr), 32'h40);
        checkOutput("wr wdata", gotWdata, 32'hDEAD_BEEF);
        checkOutput("wr ready cycle", gotReady, 3);
        checkOutput("wr err", 32'(gotErr), 32'h0);
        checkOutput("wr ready pulse", gotAfter, 0);

        runAccess(1'b0, 32'h100, 1'b0, 1'b1, 2'b00, 32'h0);
        checkOutput("rd ready cycle", gotReady, 3);
        checkOutput("rd we", 32'(gotWe), 32'h0);
        checkOutput("rd data", gotRdata, 32'hDEAD_BEEF);

        runAccess(1'b0, 32'h103, 1'b1, 1'b0, 2'b00, 32'h0000_00AB);
        checkOutput("byte we", 32'(gotWe), 32'h8);
        checkOutput("byte wdata", gotWdata, 32'hABAB_ABAB);

        runAccess(1'b0, 32'h102, 1'b1, 1'b0, 2'b01, 32'h0000_1234);
        checkOutput("half we", 32'(gotWe), 32'hC);
        checkOutput("half wdata", gotWdata, 32'h1234_1234);

        runAccess(1'b0, 32'h100, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("merged rd data", gotRdata, 32'h1234_BEEF);

        runAccess(1'b0, 32'h101, 1'b1, 1'b0, 2'b01, 32'h0000_5555);
        checkOutput("mis half ready", gotReady, 1);
        checkOutput("mis half err", 32'(gotErr), 32'h1);
        checkOutput("mis half en", gotEnCount, 0);

        runAccess(1'b0, 32'h100, 1'b1, 1'b0, 2'b11, 32'h0);
        checkOutput("size11 ready", gotReady, 1);
        checkOutput("size11 err", 32'(gotErr), 32'h1);
        checkOutput("size11 en", gotEnCount, 0);

        runAccess(1'b0, 32'h102, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("mis rd ready", gotReady, 1);
        checkOutput("mis rd err", 32'(gotErr), 32'h1);
        checkOutput("mis rd data held", gotRdata, 32'h1234_BEEF);

        runAccess(1'b0, 32'h101, 1'b1, 1'b0, 2'b00, 32'h0000_0055);
        checkOutput("byte1 we", 32'(gotWe), 32'h2);

        runAccess(1'b0, 32'h200, 1'b1, 1'b1, 2'b10, 32'hCAFE_F00D);
        checkOutput("rw is write we", 32'(gotWe), 32'hF);
        checkOutput("wr keeps rdata", gotRdata, 32'h1234_BEEF);

        runAccess(1'b0, 32'h1104, 1'b1, 1'b0, 2'b10, 32'h1111_2222);
        checkOutput("wrap addr", 32'(gotAddr), 32'h41);
        runAccess(1'b0, 32'h104, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("wrap rd data", gotRdata, 32'h1111_2222);

        runAccess(1'b0, 32'hFFFF_FFF0, 1'b1, 1'b0, 2'b00, 32'h0000_0041);
`ifdef DMEM_MMIO_EN
        checkOutput("mmio ready", gotReady, 1);
        checkOutput("mmio en", gotEnCount, 0);
        checkOutput("mmio we", 32'(gotWe), 32'h0);
        checkOutput("mmio cons count", gotConsCount, 1);
        checkOutput("mmio cons data", 32'(gotConsData), 32'h41);
        checkOutput("mmio err", 32'(gotErr), 32'h0);
        runAccess(1'b0, 32'hFFFF_FFF0, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("mmio rd ready", gotReady, 1);
        checkOutput("mmio rd data", gotRdata, 32'h0);
`else
        checkOutput("mem hi ready", gotReady, 3);
        checkOutput("mem hi en", gotEnCount, 1);
        checkOutput("mem hi addr", 32'(gotAddr), 32'h3FC);
        checkOutput("mem hi we", 32'(gotWe), 32'h1);
        checkOutput("mem hi wdata", gotWdata, 32'h4141_4141);
`endif

        runAccess(1'b1, 32'h10, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("ws3 en cycle", gotEnCycle, 1);
        checkOutput("ws3 en count", gotEnCount, 1);
        checkOutput("ws3 ready cycle", gotReady, 6);
        checkOutput("ws3 data", gotRdata, 32'hC0DE_0004);
        checkOutput("ws3 ready pulse", gotAfter, 0);

        // Reset in the middle of the WAIT phase drops the access.
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1, 2'b10, 32'h0);
        repeat (3) @(negedge clk);
        resetB = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        checkOutput("midrst ready", 32'(readyB), 32'h0);
        checkOutput("midrst en", 32'(enB), 32'h0);
        checkOutput("midrst addr", 32'(addrB), 32'h0);
        checkOutput("midrst rdata", rDataB, 32'h0);
        resetB = 1'b0;
        begin
            int readyCount = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (readyB) readyCount++;
            end
            checkOutput("midrst no ready", readyCount, 0);
        end
        runAccess(1'b1, 32'h10, 1'b0, 1'b1, 2'b10, 32'h0);
        checkOutput("postrst ready cycle", gotReady, 6);
        checkOutput("postrst data", gotRdata, 32'hC0DE_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
